gamma_loader: RTL

GAMMA_LOADER -- requirements
Module: gamma_loader

---
 rtl/gamma_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gamma_loader.sv
// gamma_loader: fills the R/G/B gamma tables from a host byte stream
// or with identity curves, and drives the shared gamma bus.
module gamma_loader #(
  parameter int TIMEOUT = 65535
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load_start,
  input  logic       linear_start,
  input  logic       enable_req,
  input  logic       data_valid,
  input  logic [7:0] data,
  output logic       data_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  inout  wire [21:0] gamma_bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [9:0] LAST = 10'd767;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LINEAR
  } state_t;

  state_t state, state_n;

  logic [9:0]    idx, idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          table_valid, tv_n;
  logic          err_n, done_n;
  logic          wr, wr_n;
  logic [9:0]    addr, addr_n;
  logic [7:0]    value, value_n;
  logic          gamma_en;
  logic          present;

  assign present = gamma_bus[21];
  assign gamma_bus[20:0] = {clk_sys, gamma_en, wr, addr, value};

  assign data_ready = (state == LOAD);
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tcnt_n  = tcnt;
    tv_n    = table_valid;
    err_n   = error;
    done_n  = 1'b0;
    wr_n    = 1'b0;
    addr_n  = addr;
    value_n = value;
    unique case (state)
      IDLE: begin
        if (load_start || linear_start) begin
          if (!present) begin
            err_n = 1'b1;
          end else begin
            state_n = load_start ? LOAD : LINEAR;
            idx_n   = '0;
            tcnt_n  = '0;
            tv_n    = 1'b0;
            err_n   = 1'b0;
          end
        end
      end
      LOAD: begin
        if (data_valid) begin
          wr_n    = 1'b1;
          addr_n  = idx;
          value_n = data;
          tcnt_n  = '0;
          if (idx == LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
            tv_n    = 1'b1;
          end else begin
            idx_n = idx + 10'd1;
          end
        end else if (tcnt == TLIM) begin
          // host went quiet: abandon the partial table
          state_n = IDLE;
          tcnt_n  = '0;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      LINEAR: begin
        wr_n    = 1'b1;
        addr_n  = idx;
        value_n = idx[7:0];
        if (idx == LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
          tv_n    = 1'b1;
        end else begin
          idx_n = idx + 10'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      tcnt        <= '0;
      table_valid <= 1'b0;
      error       <= 1'b0;
      done        <= 1'b0;
      wr          <= 1'b0;
      addr        <= '0;
      value       <= '0;
      gamma_en    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      tcnt        <= tcnt_n;
      table_valid <= tv_n;
      error       <= err_n;
      done        <= done_n;
      wr          <= wr_n;
      addr        <= addr_n;
      value       <= value_n;
      // next-state validity drops gamma_en as soon as a reload begins
      gamma_en    <= enable_req && tv_n;
    end
  end

endmodule
